// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Purpose : shared definitions for the irq_timer block: FSM state encoding,
//           register word offsets, CTRL field positions and MODE codes.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Register word offsets (byte offset bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_UNMAP  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  // MODE codes; the reserved codes 1x behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only the exact auto-reload code reloads; everything else is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/irq_timer.sv
// ---------------------------------------------------------------------------
// irq_timer
// Purpose : memory-mapped down-counter that raises a level interrupt when the
//           count, loaded from PRESET, has run down to zero. Supports one-shot
//           and auto-reload operation.
// Ports   :
//   clk    in   1   clock, all state updates on the rising edge
//   reset  in   1   asynchronous active-low reset
//   addr   in   2   word select: 0 CTRL, 1 PRESET, 2 COUNT (RO), 3 unmapped
//   we     in   1   write strobe, sampled on the rising edge
//   wdata  in  32   write data
//   rdata  out 32   combinational read of the selected register
//   irq    out  1   level interrupt = PEND & IM (flop output)
// ---------------------------------------------------------------------------
module irq_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_en;
  logic [1:0]         r_mode;
  logic               r_im;
  logic               r_pend;
  logic               r_irq;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;

  logic               w_wr_ctrl;
  logic               w_wr_preset;
  logic               w_load;
  logic               w_dec;
  logic               w_pend_set;
  logic               w_en_clr;
  logic               w_en_nxt;
  logic [1:0]         w_mode_nxt;
  logic               w_im_nxt;
  logic               w_pend_nxt;
  logic               w_irq_nxt;

  assign w_wr_ctrl   = we && (addr == ADDR_CTRL);
  assign w_wr_preset = we && (addr == ADDR_PRESET);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_pend_set  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        // Disabling freezes COUNT; the zero test keeps COUNT from wrapping.
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == '0) begin
          w_state_nxt = ST_INT;
          w_pend_set  = 1'b1;
        end else begin
          w_dec       = 1'b1;
          w_state_nxt = ST_CNT;
        end
      end
      ST_INT: begin
        if (is_reload(r_mode)) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of CTRL, PEND and irq; a CTRL write beats the one-shot EN
  // clear, and a PEND set beats the write-triggered clear.
  always_comb begin
    w_en_nxt   = r_en;
    w_mode_nxt = r_mode;
    w_im_nxt   = r_im;
    w_pend_nxt = r_pend;
    if (w_wr_ctrl) begin
      w_en_nxt   = wdata[CTRL_EN_BIT];
      w_mode_nxt = wdata[CTRL_MODE_LSB +: 2];
      w_im_nxt   = wdata[CTRL_IM_BIT];
    end else if (w_en_clr) begin
      w_en_nxt = 1'b0;
    end else begin
      w_en_nxt = r_en;
    end
    if (w_pend_set) begin
      w_pend_nxt = 1'b1;
    end else if (w_wr_ctrl || w_wr_preset) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
    // irq is flopped from the next PEND/IM so it always equals PEND & IM
    // while having no combinational path from the bus inputs.
    w_irq_nxt = w_pend_nxt & w_im_nxt;
  end

  // CTRL, PEND and irq registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_mode <= MODE_ONESHOT;
      r_im   <= 1'b0;
      r_pend <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_en   <= w_en_nxt;
      r_mode <= w_mode_nxt;
      r_im   <= w_im_nxt;
      r_pend <= w_pend_nxt;
      r_irq  <= w_irq_nxt;
    end
  end

  // PRESET register; COUNT only picks it up in LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= CNT_W'(wdata);
    end
  end

  // COUNT register: load, decrement, or hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= r_preset;
    end else if (w_dec) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read mux
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
      ADDR_PRESET: rdata = 32'(r_preset);
      ADDR_COUNT:  rdata = 32'(r_count);
      ADDR_UNMAP:  rdata = 32'd0;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_irq_timer
// Purpose : directed self-checking bench for irq_timer. Inputs change and
//           outputs are sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_irq_timer;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_timer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write; returns at the falling edge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    int irq_seen;
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    tick(2);
    reset = 1'b1;
    tick(1);

    // Reset state
    check("rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("rst_ctrl",   ADDR_CTRL,   32'd0);
    chk_rd("rst_preset", ADDR_PRESET, 32'd0);
    chk_rd("rst_count",  ADDR_COUNT,  32'd0);
    chk_rd("rst_unmap",  ADDR_UNMAP,  32'd0);
    tick(5);
    check("idle_irq", {31'd0, irq}, 32'd0);
    chk_rd("idle_count", ADDR_COUNT, 32'd0);

    // One-shot, PRESET=5: irq 8 cycles after the enable write edge
    wr(ADDR_PRESET, 32'd5);
    chk_rd("os_preset_rd", ADDR_PRESET, 32'd5);
    chk_rd("os_count_untouched", ADDR_COUNT, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    tick(2);
    chk_rd("os_count_loaded", ADDR_COUNT, 32'd5);
    tick(5);
    check("os_irq_before", {31'd0, irq}, 32'd0);
    chk_rd("os_count_zero", ADDR_COUNT, 32'd0);
    tick(1);
    check("os_irq_at8", {31'd0, irq}, 32'd1);
    tick(1);
    chk_rd("os_en_cleared", ADDR_CTRL, 32'h8);
    tick(5);
    check("os_irq_held", {31'd0, irq}, 32'd1);
    chk_rd("os_no_wrap", ADDR_COUNT, 32'd0);
    wr(ADDR_COUNT, 32'h55);
    chk_rd("os_count_ro", ADDR_COUNT, 32'd0);
    wr(ADDR_UNMAP, 32'hFFFF_FFFF);
    chk_rd("os_unmap_rd", ADDR_UNMAP, 32'd0);
    check("os_irq_after_ro_wr", {31'd0, irq}, 32'd1);

    // Auto-reload, PRESET=3: PEND every 6 cycles; rewrite clears one period
    do_reset();
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    tick(5);
    check("ar_irq_before", {31'd0, irq}, 32'd0);
    tick(1);
    check("ar_irq_first", {31'd0, irq}, 32'd1);
    tick(1);
    wr(ADDR_CTRL, 32'hB);
    check("ar_irq_cleared", {31'd0, irq}, 32'd0);
    tick(3);
    check("ar_irq_still_low", {31'd0, irq}, 32'd0);
    tick(1);
    check("ar_irq_second", {31'd0, irq}, 32'd1);
    wr(ADDR_CTRL, 32'hB);
    check("ar_irq_cleared2", {31'd0, irq}, 32'd0);
    tick(4);
    check("ar_irq_low_pre_int", {31'd0, irq}, 32'd0);
    // CTRL write on the very edge that enters INT: set wins
    wr(ADDR_CTRL, 32'hB);
    check("ar_same_edge_set", {31'd0, irq}, 32'd1);

    // PRESET=0, IM=0: INT after 3 cycles, irq masked, then PEND cleared by write
    do_reset();
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h1);
    tick(3);
    check("z_irq_masked", {31'd0, irq}, 32'd0);
    tick(1);
    chk_rd("z_oneshot_done", ADDR_CTRL, 32'd0);
    wr(ADDR_CTRL, 32'h8);
    check("z_irq_after_unmask", {31'd0, irq}, 32'd0);
    tick(3);
    check("z_irq_stays_low", {31'd0, irq}, 32'd0);

    // Mode 1x behaves as one-shot
    do_reset();
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'hD);
    tick(3);
    check("m2_irq_before", {31'd0, irq}, 32'd0);
    tick(1);
    check("m2_irq_at4", {31'd0, irq}, 32'd1);
    tick(1);
    chk_rd("m2_en_cleared", ADDR_CTRL, 32'hC);

    // Disable mid-count freezes COUNT; re-enable restarts from full PRESET
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    tick(5);
    chk_rd("dis_count7", ADDR_COUNT, 32'd7);
    wr(ADDR_CTRL, 32'h0);
    chk_rd("dis_count6", ADDR_COUNT, 32'd6);
    tick(10);
    chk_rd("dis_count_frozen", ADDR_COUNT, 32'd6);
    check("dis_no_irq", {31'd0, irq}, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    tick(2);
    chk_rd("re_count_full", ADDR_COUNT, 32'd10);
    tick(10);
    check("re_irq_before", {31'd0, irq}, 32'd0);
    tick(1);
    check("re_irq_at13", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-count
    do_reset();
    wr(ADDR_PRESET, 32'd4);
    wr(ADDR_CTRL, 32'h9);
    tick(3);
    #1;
    reset = 1'b0;
    chk_rd("ar_rst_count", ADDR_COUNT, 32'd0);
    check("ar_rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("ar_rst_ctrl", ADDR_CTRL, 32'd0);
    chk_rd("ar_rst_preset", ADDR_PRESET, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    irq_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) irq_seen++;
    end
    check("ar_rst_no_irq_20", irq_seen, 32'd0);
    chk_rd("ar_rst_idle_count", ADDR_COUNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
